// File: rtl/generation_sequencer.sv
// Sequences one Game-of-Life generation per video frame over ping-pong row BRAMs: fetches every
// row, tracks in-order next-state write-back and swaps banks only on a frame boundary.
module generation_sequencer #(
    parameter int unsigned Y_SIZE    = 720,
    parameter int unsigned Y_WIDTH   = 10,
    parameter int unsigned GEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pause,
    input  logic                 step,
    input  logic                 frame_start,
    output logic [Y_WIDTH-1:0]   fetch_addr,
    output logic                 fetch_req,
    input  logic                 fetch_ready,
    input  logic                 wr_en,
    input  logic [Y_WIDTH-1:0]   wr_addr,
    output logic                 mode,
    output logic                 busy,
    output logic [GEN_WIDTH-1:0] gen_count,
    output logic                 seq_error
);

    localparam logic [Y_WIDTH-1:0] LastRow  = Y_WIDTH'(Y_SIZE - 1);
    localparam logic [Y_WIDTH-1:0] RowCount = Y_WIDTH'(Y_SIZE);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StSwapWait
    } state_e;

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [Y_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
    logic                 fetch_req_q, fetch_req_d;
    logic                 busy_q, busy_d;
    logic [GEN_WIDTH-1:0] gen_count_q, gen_count_d;
    logic                 seq_error_q, seq_error_d;
    logic [Y_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic                 step_pend_q, step_pend_d;

    logic go;
    logic start;
    logic in_gen;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        fetch_addr_d = fetch_addr_q;
        fetch_req_d  = fetch_req_q;
        busy_d       = busy_q;
        gen_count_d  = gen_count_q;
        seq_error_d  = seq_error_q;
        wr_cnt_d     = wr_cnt_q;
        step_pend_d  = step_pend_q;
        start        = 1'b0;
        go           = ~pause | step_pend_q | step;
        in_gen       = (state_q == StFetch) || (state_q == StDrain);

        // Writes must arrive strictly in row order and only while a generation is running.
        if (wr_en) begin
            if (in_gen && (wr_addr == wr_cnt_q)) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end else begin
                seq_error_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (frame_start && go) begin
                    start = 1'b1;
                end
            end
            StFetch: begin
                if (fetch_req_q && fetch_ready) begin
                    if (fetch_addr_q == LastRow) begin
                        fetch_req_d = 1'b0;
                        state_d     = (wr_cnt_q == RowCount) ? StSwapWait : StDrain;
                    end else begin
                        fetch_addr_d = fetch_addr_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (wr_cnt_q == RowCount) begin
                    state_d = StSwapWait;
                end
            end
            StSwapWait: begin
                if (frame_start) begin
                    mode_d      = ~mode_q;
                    gen_count_d = gen_count_q + 1'b1;
                    if (go) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        if (step) begin
            step_pend_d = 1'b1;
        end

        if (start) begin
            state_d      = StFetch;
            fetch_addr_d = '0;
            fetch_req_d  = 1'b1;
            busy_d       = 1'b1;
            wr_cnt_d     = '0;
            step_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            fetch_addr_q <= '0;
            fetch_req_q  <= 1'b0;
            busy_q       <= 1'b0;
            gen_count_q  <= '0;
            seq_error_q  <= 1'b0;
            wr_cnt_q     <= '0;
            step_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_req_q  <= fetch_req_d;
            busy_q       <= busy_d;
            gen_count_q  <= gen_count_d;
            seq_error_q  <= seq_error_d;
            wr_cnt_q     <= wr_cnt_d;
            step_pend_q  <= step_pend_d;
        end
    end

    assign fetch_addr = fetch_addr_q;
    assign fetch_req  = fetch_req_q;
    assign mode       = mode_q;
    assign busy       = busy_q;
    assign gen_count  = gen_count_q;
    assign seq_error  = seq_error_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Bench for generation_sequencer: row/write counting model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_generation_sequencer;

    localparam int Y = 720;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] fetch_addr;
    logic       fetch_req;
    logic       fetch_ready = 1'b0;
    logic       wr_en = 1'b0;
    logic [9:0] wr_addr = '0;
    logic       mode;
    logic       busy;
    logic [15:0] gen_count;
    logic       seq_error;

    generation_sequencer #(
        .Y_SIZE    (Y),
        .Y_WIDTH   (10),
        .GEN_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .step        (step),
        .frame_start (frame_start),
        .fetch_addr  (fetch_addr),
        .fetch_req   (fetch_req),
        .fetch_ready (fetch_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .mode        (mode),
        .busy        (busy),
        .gen_count   (gen_count),
        .seq_error   (seq_error)
    );

    always #5 clk = ~clk;

    // Stimulus controls set by the main sequence.
    int         ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
    bit         auto_wr = 1'b1;
    logic       man_wr_en = 1'b0;
    logic [9:0] man_wr_addr = '0;

    // Counters: main-sequence literals and the per-cycle compare process.
    int m_chk = 0, m_err = 0, c_chk = 0, c_err = 0;
    int n_acc = 0;

    // Line-buffer / writer stand-in: writes row k three cycles after fetch k is accepted.
    bit         pv [3];
    logic [9:0] pa [3];
    int         cyc = 0;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] = 1'b0;
                pa[i] = '0;
            end
        end else begin
            pv[2] = pv[1]; pa[2] = pa[1];
            pv[1] = pv[0]; pa[1] = pa[0];
            pv[0] = fetch_req && fetch_ready;
            pa[0] = fetch_addr;
        end
        cyc++;
        #2;
        wr_en       = auto_wr ? pv[2] : man_wr_en;
        wr_addr     = auto_wr ? pa[2] : man_wr_addr;
        fetch_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? cyc[0] : 1'b0;
    end

    // Behavioural model in terms of rows fetched and rows written back.
    bit m_valid = 1'b0, m_active, m_done, m_mode, m_err_f, m_sp;
    int m_fetched, m_written, m_gen;
    always @(posedge clk) begin
        int fp, wp;
        bit go, start;
        if (rst) begin
            m_active = 0; m_done = 0; m_fetched = 0; m_written = 0;
            m_mode = 0; m_gen = 0; m_err_f = 0; m_sp = 0; m_valid = 1;
        end else begin
            fp = m_fetched;
            wp = m_written;
            go = !pause || m_sp || step;
            start = 0;
            if (wr_en) begin
                if (m_active && !m_done && int'(wr_addr) == wp) m_written = wp + 1;
                else m_err_f = 1;
            end
            if (!m_active) begin
                start = frame_start && go;
            end else if (m_done) begin
                if (frame_start) begin
                    m_mode = !m_mode;
                    m_gen  = (m_gen + 1) % 65536;
                    if (go) start = 1;
                    else begin
                        m_active = 0;
                        m_done   = 0;
                    end
                end
            end else begin
                if (fp < Y && fetch_ready) m_fetched = fp + 1;
                if (m_fetched == Y && wp == Y) m_done = 1;
            end
            if (step) m_sp = 1;
            if (start) begin
                m_active = 1; m_done = 0; m_fetched = 0; m_written = 0; m_sp = 0;
            end
        end
    end

    int exp_next = 0;
    always @(negedge clk) begin
        bit exp_req;
        int exp_addr;
        if (m_valid) begin
            exp_req  = m_active && !m_done && (m_fetched < Y);
            exp_addr = (m_fetched >= Y) ? Y - 1 : m_fetched;
            c_chk++;
            if (fetch_req !== exp_req || int'(fetch_addr) != exp_addr || mode !== m_mode ||
                busy !== m_active || int'(gen_count) != m_gen || seq_error !== m_err_f) begin
                c_err++;
                $display("FAIL cycle_model t=%0t got req=%b addr=%0d mode=%b busy=%b gen=%0d err=%b required req=%b addr=%0d mode=%b busy=%b gen=%0d err=%b",
                         $time, fetch_req, fetch_addr, mode, busy, gen_count, seq_error,
                         exp_req, exp_addr, m_mode, m_active, m_gen, m_err_f);
            end
            if (rst) begin
                exp_next = 0;
            end else if (fetch_req && fetch_ready) begin
                c_chk++;
                if (int'(fetch_addr) != exp_next) begin
                    c_err++;
                    $display("FAIL fetch_order got %0d required %0d", fetch_addr, exp_next);
                end
                n_acc++;
                exp_next = (exp_next == Y - 1) ? 0 : exp_next + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        m_chk++;
        if (act !== req) begin
            m_err++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic wait_addr(input int a);
        int k = 0;
        while (int'(fetch_addr) != a && k < 2000) begin
            tick();
            k++;
        end
        check("reach_addr", 32'(fetch_addr), 32'(a));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        ticks(2);
        check("rst_mode", 32'(mode), 0);
        check("rst_req", 32'(fetch_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gen", 32'(gen_count), 0);
        rst = 1'b0;

        // 1: free-running generation
        tick();
        pulse_fs();
        check("t1_req", 32'(fetch_req), 1);
        check("t1_addr0", 32'(fetch_addr), 0);
        tick();
        check("t1_addr1", 32'(fetch_addr), 1);
        ticks(730);
        check("t1_wait_busy", 32'(busy), 1);
        check("t1_wait_req", 32'(fetch_req), 0);
        check("t1_wait_mode", 32'(mode), 0);
        pulse_fs();
        check("t1_mode", 32'(mode), 1);
        check("t1_gen", 32'(gen_count), 1);
        check("t1_restart_req", 32'(fetch_req), 1);
        check("t1_restart_addr", 32'(fetch_addr), 0);

        // 2: paused, then a single step
        do_reset();
        pause = 1'b1;
        repeat (3) begin
            pulse_fs();
            ticks(3);
            check("t2_paused_req", 32'(fetch_req), 0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        ticks(2);
        pulse_fs();
        check("t2_step_req", 32'(fetch_req), 1);
        ticks(735);
        pulse_fs();
        check("t2_mode", 32'(mode), 1);
        check("t2_gen", 32'(gen_count), 1);
        check("t2_idle", 32'(busy), 0);
        pulse_fs();
        ticks(2);
        check("t2_no_second", 32'(busy), 0);

        // 3: fetch_ready toggling
        do_reset();
        pause = 1'b0;
        ready_mode = 1;
        n0 = n_acc;
        pulse_fs();
        ticks(1480);
        check("t3_accepted", 32'(n_acc - n0), 720);
        check("t3_req_done", 32'(fetch_req), 0);
        pulse_fs();
        check("t3_mode", 32'(mode), 1);
        ready_mode = 0;

        // 4: pause raised mid-generation
        do_reset();
        pulse_fs();
        wait_addr(300);
        pause = 1'b1;
        ticks(450);
        check("t4_busy", 32'(busy), 1);
        pulse_fs();
        check("t4_mode", 32'(mode), 1);
        check("t4_idle", 32'(busy), 0);
        pulse_fs();
        ticks(3);
        pulse_fs();
        check("t4_stay_idle", 32'(busy), 0);
        check("t4_gen", 32'(gen_count), 1);

        // 5: out-of-order write, sticky error
        do_reset();
        pause = 1'b0;
        auto_wr = 1'b0;
        ready_mode = 2;
        pulse_fs();
        for (int i = 0; i < 4; i++) begin
            man_wr_en = 1'b1;
            man_wr_addr = 10'(i);
            tick();
        end
        man_wr_addr = 10'd5;
        tick();
        man_wr_en = 1'b0;
        ticks(2);
        check("t5_err", 32'(seq_error), 1);
        ready_mode = 0;
        for (int i = 4; i < Y; i++) begin
            man_wr_en = 1'b1;
            man_wr_addr = 10'(i);
            tick();
        end
        man_wr_en = 1'b0;
        auto_wr = 1'b1;
        ticks(10);
        pulse_fs();
        check("t5_gen1", 32'(gen_count), 1);
        ticks(740);
        pulse_fs();
        check("t5_gen2", 32'(gen_count), 2);
        check("t5_err_held", 32'(seq_error), 1);
        do_reset();
        check("t5_err_cleared", 32'(seq_error), 0);
        pause = 1'b1;
        auto_wr = 1'b0;
        man_wr_en = 1'b1;
        man_wr_addr = '0;
        tick();
        man_wr_en = 1'b0;
        ticks(2);
        check("t5_idle_write", 32'(seq_error), 1);
        auto_wr = 1'b1;
        pause = 1'b0;

        // 6: reset mid-fetch
        do_reset();
        pulse_fs();
        wait_addr(100);
        rst = 1'b1;
        tick();
        check("t6_addr", 32'(fetch_addr), 0);
        check("t6_req", 32'(fetch_req), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_mode", 32'(mode), 0);
        rst = 1'b0;
        ticks(4);
        pulse_fs();
        check("t6_restart_req", 32'(fetch_req), 1);
        check("t6_restart_addr", 32'(fetch_addr), 0);
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", m_chk + c_chk, m_err + c_err);
        $finish;
    end

endmodule
